// File: rtl/line_raster_pkg.sv
// ---------------------------------------------------------------------------
// line_raster_pkg
// Shared types and constants for the Bresenham line rasteriser.
//   - raster_state_t : control states of the rasteriser
//   - DIR_POS/DIR_NEG: encoding of a per-axis step direction
//   - COORD_W_DEF    : default coordinate width
//   - err_width()    : width of the signed error datapath for a coordinate
//                      width (two extra bits: sign plus headroom for dx+dy)
// ---------------------------------------------------------------------------
package line_raster_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2
    } raster_state_t;

    // One bit per axis: 0 steps towards larger coordinates, 1 towards smaller.
    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

    localparam int COORD_W_DEF = 8;

    function automatic int err_width(input int coord_w);
        return coord_w + 2;
    endfunction

endpackage

// File: rtl/line_raster_step.sv
// ---------------------------------------------------------------------------
// line_raster_step
// Combinational single Bresenham step from the current pixel.
//   i_x, i_y     : current pixel
//   i_x1, i_y1   : line endpoint
//   i_err        : current error term
//   i_dx, i_dy   : |x1-x0| and -|y1-y0|
//   i_sx, i_sy   : step directions (DIR_POS / DIR_NEG)
//   o_nx, o_ny   : next pixel
//   o_nerr       : next error term
//   o_at_end     : next pixel is the endpoint
// ---------------------------------------------------------------------------
module line_raster_step
    import line_raster_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int ERR_W   = err_width(COORD_W)
) (
    input  logic        [COORD_W-1:0] i_x,
    input  logic        [COORD_W-1:0] i_y,
    input  logic        [COORD_W-1:0] i_x1,
    input  logic        [COORD_W-1:0] i_y1,
    input  logic signed [ERR_W-1:0]   i_err,
    input  logic signed [ERR_W-1:0]   i_dx,
    input  logic signed [ERR_W-1:0]   i_dy,
    input  logic                      i_sx,
    input  logic                      i_sy,
    output logic        [COORD_W-1:0] o_nx,
    output logic        [COORD_W-1:0] o_ny,
    output logic signed [ERR_W-1:0]   o_nerr,
    output logic                      o_at_end
);

    // 2*err needs one bit more than err itself; compare at that width.
    logic signed [ERR_W:0] w_e2;
    logic signed [ERR_W:0] w_dx_ext;
    logic signed [ERR_W:0] w_dy_ext;
    logic                  w_step_x;
    logic                  w_step_y;

    assign w_e2     = $signed({i_err, 1'b0});
    assign w_dx_ext = $signed({i_dx[ERR_W-1], i_dx});
    assign w_dy_ext = $signed({i_dy[ERR_W-1], i_dy});

    // Both decisions use the same e2, so a diagonal step moves both axes.
    assign w_step_x = (w_e2 >= w_dy_ext);
    assign w_step_y = (w_e2 <= w_dx_ext);

    always_comb begin
        o_nx = i_x;
        o_ny = i_y;
        if (w_step_x) o_nx = (i_sx == DIR_NEG) ? i_x - COORD_W'(1) : i_x + COORD_W'(1);
        if (w_step_y) o_ny = (i_sy == DIR_NEG) ? i_y - COORD_W'(1) : i_y + COORD_W'(1);
    end

    assign o_nerr   = i_err + (w_step_x ? i_dy : '0) + (w_step_y ? i_dx : '0);
    assign o_at_end = (o_nx == i_x1) && (o_ny == i_y1);

endmodule

// File: rtl/line_raster.sv
// ---------------------------------------------------------------------------
// line_raster
// Bresenham line rasteriser for all octants. Takes one (x0,y0)->(x1,y1)
// command over valid/ready and streams every pixel of the line, endpoints
// included, over a backpressured valid/ready pixel port with a last flag.
//
// Optional feature macro: LINE_PATTERN_EN
//   adds parameter PATTERN_W, input cmd_pattern and output pix_draw, where
//   pix_draw = cmd_pattern[i mod PATTERN_W] for 0-based pixel index i.
//
// Ports
//   ACLK, ARESETN          clock (posedge), async active-low reset
//   cmd_valid/cmd_ready    command handshake (ready only in IDLE)
//   cmd_x0..cmd_y1         line endpoints, latched at the handshake
//   pix_valid/pix_ready    pixel handshake
//   pix_x, pix_y, pix_last current pixel, last marks the endpoint
//   busy                   not IDLE
//   done                   one-cycle pulse after the last pixel handshake
// ---------------------------------------------------------------------------
module line_raster
    import line_raster_pkg::*;
#(
    parameter int COORD_W   = COORD_W_DEF
`ifdef LINE_PATTERN_EN
   ,parameter int PATTERN_W = 16
`endif
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] cmd_x0,
    input  logic [COORD_W-1:0] cmd_y0,
    input  logic [COORD_W-1:0] cmd_x1,
    input  logic [COORD_W-1:0] cmd_y1,
`ifdef LINE_PATTERN_EN
    input  logic [PATTERN_W-1:0] cmd_pattern,
    output logic               pix_draw,
`endif
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_last,
    output logic               busy,
    output logic               done
);

    localparam int ERR_W = err_width(COORD_W);

    raster_state_t r_state, w_state_nxt;

    // r_x/r_y hold x0/y0 from the handshake until SETUP, then the live pixel.
    logic        [COORD_W-1:0] r_x, r_y, r_x1, r_y1;
    logic signed [ERR_W-1:0]   r_err, r_dx, r_dy;
    logic                      r_sx, r_sy;
    logic                      r_pix_valid, r_pix_last, r_done;

    logic signed [ERR_W-1:0]   w_ddx, w_ddy, w_adx, w_ady;
    logic        [COORD_W-1:0] w_nx, w_ny;
    logic signed [ERR_W-1:0]   w_nerr;
    logic                      w_at_end;
    logic                      w_cmd_hs, w_pix_hs;

    assign w_cmd_hs = cmd_valid && cmd_ready;
    assign w_pix_hs = r_pix_valid && pix_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (cmd_valid) w_state_nxt = SETUP;
            SETUP:   w_state_nxt = RUN;
            RUN:     if (w_pix_hs && r_pix_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        cmd_ready = (r_state == IDLE);
        busy      = (r_state != IDLE);
    end

    // ---------------- setup arithmetic ----------------
    assign w_ddx = $signed({2'b00, r_x1}) - $signed({2'b00, r_x});
    assign w_ddy = $signed({2'b00, r_y1}) - $signed({2'b00, r_y});
    assign w_adx = w_ddx[ERR_W-1] ? -w_ddx : w_ddx;
    assign w_ady = w_ddy[ERR_W-1] ? -w_ddy : w_ddy;

    line_raster_step #(
        .COORD_W (COORD_W),
        .ERR_W   (ERR_W)
    ) u_step (
        .i_x      (r_x),
        .i_y      (r_y),
        .i_x1     (r_x1),
        .i_y1     (r_y1),
        .i_err    (r_err),
        .i_dx     (r_dx),
        .i_dy     (r_dy),
        .i_sx     (r_sx),
        .i_sy     (r_sy),
        .o_nx     (w_nx),
        .o_ny     (w_ny),
        .o_nerr   (w_nerr),
        .o_at_end (w_at_end)
    );

    // ---------------- datapath ----------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_x         <= '0;
            r_y         <= '0;
            r_x1        <= '0;
            r_y1        <= '0;
            r_err       <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_sx        <= DIR_POS;
            r_sy        <= DIR_POS;
            r_pix_valid <= 1'b0;
            r_pix_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cmd_hs) begin
                        r_x  <= cmd_x0;
                        r_y  <= cmd_y0;
                        r_x1 <= cmd_x1;
                        r_y1 <= cmd_y1;
                    end
                end
                SETUP: begin
                    r_dx        <= w_adx;
                    r_dy        <= -w_ady;
                    r_err       <= w_adx - w_ady;
                    r_sx        <= (r_x1 >= r_x) ? DIR_POS : DIR_NEG;
                    r_sy        <= (r_y1 >= r_y) ? DIR_POS : DIR_NEG;
                    r_pix_valid <= 1'b1;
                    // Degenerate line: the first pixel is already the endpoint.
                    r_pix_last  <= (r_x == r_x1) && (r_y == r_y1);
                end
                RUN: begin
                    if (w_pix_hs) begin
                        if (r_pix_last) begin
                            r_pix_valid <= 1'b0;
                            r_pix_last  <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_x        <= w_nx;
                            r_y        <= w_ny;
                            r_err      <= w_nerr;
                            r_pix_last <= w_at_end;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pix_valid = r_pix_valid;
    assign pix_x     = r_x;
    assign pix_y     = r_y;
    assign pix_last  = r_pix_last;
    assign done      = r_done;

`ifdef LINE_PATTERN_EN
    localparam int IDX_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;

    logic [PATTERN_W-1:0] r_pattern;
    logic [IDX_W-1:0]     r_idx;

    // Index wraps at PATTERN_W explicitly so non-power-of-two lengths work.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_pattern <= '0;
            r_idx     <= '0;
        end else begin
            if (w_cmd_hs) begin
                r_pattern <= cmd_pattern;
                r_idx     <= '0;
            end else if (r_state == RUN && w_pix_hs && !r_pix_last) begin
                r_idx <= (r_idx == IDX_W'(PATTERN_W - 1)) ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    assign pix_draw = r_pattern[r_idx];
`endif

endmodule

// File: tb/tb_line_raster.sv
module tb_line_raster;
    import line_raster_pkg::*;

    localparam int CW = 8;
`ifdef LINE_PATTERN_EN
    localparam int PW = 4;
`endif

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [CW-1:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
    logic          pix_valid;
    logic          pix_ready = 1'b0;
    logic [CW-1:0] pix_x, pix_y;
    logic          pix_last, busy, done;
`ifdef LINE_PATTERN_EN
    logic [PW-1:0] cmd_pattern = '0;
    logic          pix_draw;
`endif

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    line_raster #(
        .COORD_W (CW)
`ifdef LINE_PATTERN_EN
       ,.PATTERN_W (PW)
`endif
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_x1    (cmd_x1),
        .cmd_y1    (cmd_y1),
`ifdef LINE_PATTERN_EN
        .cmd_pattern (cmd_pattern),
        .pix_draw    (pix_draw),
`endif
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_last  (pix_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Reference: list of pixels from the error-term rules in plain integers.
    int exp_x[$];
    int exp_y[$];

    task automatic build_ref(input int x0, input int y0, input int x1, input int y1);
        int dx, dy, sx, sy, err, x, y, e2;
        exp_x.delete();
        exp_y.delete();
        dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy  = -((y1 > y0) ? y1 - y0 : y0 - y1);
        sx  = (x1 >= x0) ? 1 : -1;
        sy  = (y1 >= y0) ? 1 : -1;
        err = dx + dy;
        x = x0;
        y = y0;
        forever begin
            exp_x.push_back(x);
            exp_y.push_back(y);
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    function automatic int ready_for(input int mode, input int cyc);
        if (mode == 0) return 1;
        if (mode == 1) return (cyc % 3 == 2) ? 1 : 0;   // 1,0,0,1,0,0,...
        return int'($urandom_range(0, 1));
    endfunction

    // mode: 0 always ready, 1 fixed 1,0,0 ready pattern, 2 random ready
    int got_x[$];
    int got_y[$];

    task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                            input logic [15:0] pat, input int mode);
        int  n, idx, cyc;
        bit  held, got_last;
        int  hold_v;
        build_ref(x0, y0, x1, y1);
        n = exp_x.size();
        got_x.delete();
        got_y.delete();
        @(negedge ACLK);
        pix_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_x0 = CW'(x0); cmd_y0 = CW'(y0); cmd_x1 = CW'(x1); cmd_y1 = CW'(y1);
`ifdef LINE_PATTERN_EN
        cmd_pattern = pat[PW-1:0];
`endif
        chk("cmd_ready_idle", int'(cmd_ready), 1);
        @(negedge ACLK);
        // Scramble the command inputs: the block must use the latched copy.
        cmd_valid = 1'b0;
        cmd_x0 = CW'($urandom); cmd_y0 = CW'($urandom);
        cmd_x1 = CW'($urandom); cmd_y1 = CW'($urandom);
        chk("setup_no_pix", int'(pix_valid), 0);
        chk("setup_busy_noready", int'({busy, cmd_ready}), 2);
        idx = 0; cyc = 1; held = 0; got_last = 0; hold_v = 0;
        while (!got_last && cyc < 3000) begin
            @(negedge ACLK);
            cyc++;
            pix_ready = ready_for(mode, cyc) != 0;
            if (cyc == 2) chk("first_pix_latency", int'(pix_valid), 1);
            if (held) chk("stall_stable", int'({pix_valid, pix_x, pix_y, pix_last}), hold_v);
            if (pix_valid && pix_ready) begin
                if (idx < n)
                    chk($sformatf("pix%0d_xyl", idx), int'({pix_x, pix_y, pix_last}),
                        (exp_x[idx] << 9) | (exp_y[idx] << 1) | ((idx == n - 1) ? 1 : 0));
                else
                    chk("extra_pixel", idx, n - 1);
`ifdef LINE_PATTERN_EN
                chk($sformatf("pix%0d_draw", idx), int'(pix_draw), int'(pat[idx % PW]));
`endif
                got_x.push_back(int'(pix_x));
                got_y.push_back(int'(pix_y));
                idx++;
                if (pix_last) got_last = 1;
                held = 0;
            end else begin
                held   = pix_valid;
                hold_v = int'({pix_valid, pix_x, pix_y, pix_last});
            end
        end
        if (!got_last) begin
            chk("line_timeout", cyc, -1);
        end else begin
            @(negedge ACLK);
            cyc++;
            pix_ready = 1'b0;
            chk("done_pulse", int'({done, busy, cmd_ready}), 5);
            chk("pix_count", idx, n);
            if (mode == 0) chk("done_cycle", cyc, n + 2);
            @(negedge ACLK);
            chk("done_one_cycle", int'(done), 0);
        end
    endtask

    typedef struct {
        int x0, y0, x1, y1;
        int n;           // expected pixel count, max(|dx|,|dy|)+1
        int mode;
    } vec_t;

    vec_t tbl[$];

    initial begin
        bit bad;
        int k;
        int ref_y1 [8];
        // Fixed y sequence for (2,3)->(9,5): ideal y = 3+2(x-2)/7 rounded
        ref_y1 = '{3, 3, 4, 4, 4, 4, 5, 5};

        tbl.push_back('{2, 3, 9, 5, 8, 0});
        tbl.push_back('{10, 10, 10, 10, 1, 0});
        tbl.push_back('{200, 50, 190, 60, 11, 0});
        tbl.push_back('{2, 3, 9, 5, 8, 1});
        tbl.push_back('{0, 0, 255, 0, 256, 0});
        tbl.push_back('{255, 255, 0, 0, 256, 2});
        tbl.push_back('{0, 255, 255, 0, 256, 0});
        tbl.push_back('{5, 0, 5, 20, 21, 2});
        tbl.push_back('{40, 9, 3, 30, 38, 1});

        // Reset state
        #2;
        chk("rst_outputs", int'({pix_valid, pix_x, pix_y, pix_last, busy, done}), 0);
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("rst_cmd_ready", int'(cmd_ready), 1);

        // Table-driven lines
        foreach (tbl[i]) begin
            run_line(tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, 16'h0, tbl[i].mode);
            chk($sformatf("tbl%0d_count", i), got_x.size(), tbl[i].n);
            if (got_x.size() > 0)
                chk($sformatf("tbl%0d_end", i), (got_x[$] << 9) | got_y[$],
                    (tbl[i].x1 << 9) | tbl[i].y1);
            if (i == 0 || i == 3) begin
                bad = (got_x.size() != 8);
                for (int j = 0; j < got_x.size() && j < 8; j++)
                    if (got_x[j] != 2 + j || got_y[j] != ref_y1[j]) bad = 1;
                chk($sformatf("tbl%0d_seq_2_3_9_5", i), int'(bad), 0);
            end
            if (i == 2) begin
                bad = 0;
                for (int j = 0; j < got_x.size(); j++)
                    if (got_x[j] != 200 - j || got_y[j] != 50 + j) bad = 1;
                chk("tbl2_diag_seq", int'(bad), 0);
            end
        end

        // Reset while the line is being drawn
        @(negedge ACLK);
        cmd_valid = 1'b1;
        cmd_x0 = 0; cmd_y0 = 0; cmd_x1 = 255; cmd_y1 = 255;
        @(negedge ACLK);
        cmd_valid = 1'b0;
        pix_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            @(negedge ACLK);
            if (pix_valid && pix_ready) k++;
        end
        @(negedge ACLK);
        chk("abort_at_pix4", int'({pix_valid, pix_x, pix_y}), (1 << 16) | (4 << 8) | 4);
        ARESETN = 1'b0;
        #1;
        chk("abort_rst_outputs", int'({pix_valid, pix_x, pix_y, pix_last, busy, done}), 0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge ACLK);
            if (done || pix_valid || busy) bad = 1;
        end
        chk("abort_no_done", int'(bad), 0);
        run_line(17, 33, 40, 20, 16'h0, 0);
        if (got_x.size() > 0) chk("after_abort_start", (got_x[0] << 9) | got_y[0], (17 << 9) | 33);

`ifdef LINE_PATTERN_EN
        run_line(0, 0, 7, 0, 16'h0003, 0);
        run_line(9, 1, 0, 3, 16'h0005, 2);
`endif

        // Randomized lines against the reference
        for (int r = 0; r < 16; r++) begin
            int x0, y0, x1, y1;
            x0 = int'($urandom_range(0, 255));
            y0 = int'($urandom_range(0, 255));
            if (r % 2 == 0) begin
                x1 = int'($urandom_range(0, 255));
                y1 = int'($urandom_range(0, 255));
            end else begin
                x1 = (x0 + int'($urandom_range(0, 20))) % 256;
                y1 = (y0 + 256 - int'($urandom_range(0, 20))) % 256;
            end
            run_line(x0, y0, x1, y1, 16'($urandom), 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
